// File: rtl/binary16_div_arbiter_pkg.sv
// ============================================================================
// binary16_div_arbiter_pkg : shared constants and state encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package binary16_div_arbiter_pkg;

  localparam logic [15:0] BINARY16_QNAN       = 16'h7E00;
  localparam int          DIV_NOMINAL_LATENCY = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESPOND = 3'd4
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/binary16_div_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick starting after last_grant
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   last_grant,
  output logic [TAG_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [TAG_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = TAG_W'((int'(last_grant) + off) % NUM_REQ);
      if (req[cand]) begin
        grant_idx = cand;
        any_req   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/binary16_div_arbiter.sv
// ============================================================================
// binary16_div_arbiter : shares one binary16 divider among NUM_REQ lanes
// Revision : 1.0
// ============================================================================
`default_nettype none

module binary16_div_arbiter
  import binary16_div_arbiter_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  TIMEOUT_CYCLES = 63,
  localparam int TAG_W          = $clog2(NUM_REQ)
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*16-1:0] req_a,
  input  logic [NUM_REQ*16-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [15:0]           rsp_result,
  output logic                  rsp_error,
  output logic [15:0]           div_a,
  output logic [15:0]           div_b,
  output logic                  div_valid_in,
  input  logic [15:0]           div_result,
  input  logic                  div_valid_out,
  output logic                  busy,
  output logic [7:0]            timeout_count
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t       state, state_nxt;
  logic [TAG_W-1:0] last_grant, last_grant_nxt;
  logic [TAG_W-1:0] tag, tag_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [NUM_REQ-1:0] req_ready_nxt, rsp_valid_nxt;
  logic [15:0]      rsp_result_nxt, div_a_nxt, div_b_nxt;
  logic             rsp_error_nxt, div_valid_in_nxt, busy_nxt;
  logic [7:0]       timeout_count_nxt;
  logic [TAG_W-1:0] pick;
  logic             any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant_idx  (pick),
    .any_req    (any_req)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      last_grant    <= TAG_W'(NUM_REQ - 1);
      tag           <= '0;
      timer         <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      rsp_error     <= 1'b0;
      div_a         <= '0;
      div_b         <= '0;
      div_valid_in  <= 1'b0;
      busy          <= 1'b0;
      timeout_count <= '0;
    end else begin
      state         <= state_nxt;
      last_grant    <= last_grant_nxt;
      tag           <= tag_nxt;
      timer         <= timer_nxt;
      req_ready     <= req_ready_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_result    <= rsp_result_nxt;
      rsp_error     <= rsp_error_nxt;
      div_a         <= div_a_nxt;
      div_b         <= div_b_nxt;
      div_valid_in  <= div_valid_in_nxt;
      busy          <= busy_nxt;
      timeout_count <= timeout_count_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    last_grant_nxt    = last_grant;
    tag_nxt           = tag;
    timer_nxt         = timer;
    req_ready_nxt     = req_ready;
    rsp_valid_nxt     = rsp_valid;
    rsp_result_nxt    = rsp_result;
    rsp_error_nxt     = rsp_error;
    div_a_nxt         = div_a;
    div_b_nxt         = div_b;
    div_valid_in_nxt  = div_valid_in;
    timeout_count_nxt = timeout_count;

    case (state)
      ST_IDLE: begin
        if (any_req) begin
          tag_nxt       = pick;
          req_ready_nxt = NUM_REQ'(1) << pick;
          state_nxt     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        req_ready_nxt    = '0;
        div_a_nxt        = req_a[int'(tag)*16 +: 16];
        div_b_nxt        = req_b[int'(tag)*16 +: 16];
        div_valid_in_nxt = 1'b1;
        state_nxt        = ST_ISSUE;
      end
      ST_ISSUE: begin
        div_valid_in_nxt = 1'b0;
        timer_nxt        = '0;
        state_nxt        = ST_WAIT;
      end
      ST_WAIT: begin
        timer_nxt = timer + 1'b1;
        // A completion in the timeout cycle takes precedence over the watchdog.
        if (div_valid_out) begin
          rsp_result_nxt = div_result;
          rsp_error_nxt  = 1'b0;
          rsp_valid_nxt  = NUM_REQ'(1) << tag;
          state_nxt      = ST_RESPOND;
        end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_result_nxt = BINARY16_QNAN;
          rsp_error_nxt  = 1'b1;
          rsp_valid_nxt  = NUM_REQ'(1) << tag;
          if (timeout_count != 8'hFF) timeout_count_nxt = timeout_count + 8'd1;
          state_nxt      = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready[tag]) begin
          rsp_valid_nxt  = '0;
          last_grant_nxt = tag;
          state_nxt      = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_binary16_div_arbiter.sv
// ============================================================================
// tb_binary16_div_arbiter : directed checks with a latency-programmable divider model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_binary16_div_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_a, req_b;
  logic [15:0] rsp_result, div_a, div_b;
  logic [15:0] div_result = 16'h0;
  logic        rsp_error, div_valid_in, busy;
  logic        div_valid_out = 1'b0;
  logic [7:0]  timeout_count;

  int n_checks = 0;
  int n_errors = 0;

  binary16_div_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(63)) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_error     (rsp_error),
    .div_a         (div_a),
    .div_b         (div_b),
    .div_valid_in  (div_valid_in),
    .div_result    (div_result),
    .div_valid_out (div_valid_out),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  always #5 clk_in = ~clk_in;

  // Divider model: model_lat cycles after the start pulse (0 = never answers);
  // inj_req bumps force a single stray pulse.
  int          model_lat = 24;
  logic [15:0] model_result = 16'h0;
  int          inj_req = 0;
  int          inj_done = 0;
  logic [15:0] inj_val = 16'h0;
  int          cnt = -1;

  always @(posedge clk_in) begin
    #1;
    div_valid_out = 1'b0;
    if (!rst_n) begin
      cnt = -1;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          div_valid_out = 1'b1;
          div_result    = model_result;
          cnt           = -1;
        end
      end
      if (div_valid_in && model_lat > 0) cnt = model_lat;
    end
    if (inj_req != inj_done) begin
      div_valid_out = 1'b1;
      div_result    = inj_val;
      inj_done      = inj_req;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one operation to completion; hold>0 keeps the owner's rsp_ready low
  // (non-owners high) for that many cycles and counts unstable cycles in bad.
  task automatic run_op(input int max_cyc, input bit keep_valid, input logic [3:0] add_mask,
                        input int hold, output logic [3:0] gnt, output logic [3:0] owner,
                        output logic [15:0] res, output logic err, output int lat, output int bad);
    int issue_k;
    bit done;
    logic [3:0] prev_rdy;
    gnt = '0; owner = '0; res = '0; err = 1'b0; lat = -1; bad = 0;
    issue_k = -1; done = 1'b0; prev_rdy = '0;
    for (int k = 1; k <= max_cyc && !done; k++) begin
      @(posedge clk_in); #1;
      if (prev_rdy != 4'b0) begin
        if (!keep_valid) req_valid = req_valid & ~prev_rdy;
        req_valid = req_valid | add_mask;
      end
      prev_rdy = req_ready;
      if (req_ready != 4'b0) gnt = req_ready;
      if (div_valid_in) issue_k = k;
      if (rsp_valid != 4'b0) begin
        owner = rsp_valid; res = rsp_result; err = rsp_error; lat = k - issue_k;
        for (int h = 0; h < hold; h++) begin
          rsp_ready = ~owner;
          @(posedge clk_in); #1;
          if (rsp_valid !== owner || rsp_result !== res || rsp_error !== err || req_ready !== 4'b0)
            bad++;
        end
        rsp_ready = owner;
        @(posedge clk_in); #1;
        rsp_ready = '0;
        if (rsp_valid !== 4'b0) bad++;
        done = 1'b1;
      end
    end
    check("op_completed", 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req_ready"},  32'(req_ready),     32'd0);
    check({pfx, "_rsp_valid"},  32'(rsp_valid),     32'd0);
    check({pfx, "_rsp_result"}, 32'(rsp_result),    32'd0);
    check({pfx, "_rsp_error"},  32'(rsp_error),     32'd0);
    check({pfx, "_div_a"},      32'(div_a),         32'd0);
    check({pfx, "_div_b"},      32'(div_b),         32'd0);
    check({pfx, "_div_vin"},    32'(div_valid_in),  32'd0);
    check({pfx, "_busy"},       32'(busy),          32'd0);
    check({pfx, "_tocount"},    32'(timeout_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0]  gnt, owner;
    logic [15:0] res;
    logic        err;
    int          lat, bad, extra;
    bit          seen;
    logic [3:0]  rr_exp [6];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check_all_zero("reset");
    @(negedge clk_in);
    rst_n = 1'b1;

    // Round robin from reset with every lane requesting continuously.
    req_a = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    req_b = {4{16'h3C00}};
    model_lat = 24; model_result = 16'h4000;
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      run_op(80, 1'b1, 4'b0, 0, gnt, owner, res, err, lat, bad);
      check($sformatf("rr_grant%0d", i), 32'(gnt),   32'(rr_exp[i]));
      check($sformatf("rr_owner%0d", i), 32'(owner), 32'(rr_exp[i]));
    end
    req_valid = '0;

    // Single op: 2.0 / 1.0
    req_a[15:0] = 16'h4000; req_b[15:0] = 16'h3C00;
    req_valid = 4'b0001;
    run_op(80, 1'b0, 4'b0, 0, gnt, owner, res, err, lat, bad);
    check("single_grant",  32'(gnt),   32'h1);
    check("single_owner",  32'(owner), 32'h1);
    check("single_result", 32'(res),   32'h4000);
    check("single_error",  32'(err),   32'd0);
    check("single_latency", 32'(lat),  32'd25);
    check("single_div_a",  32'(div_a), 32'h4000);
    check("single_div_b",  32'(div_b), 32'h3C00);

    // Watchdog: divider never answers, then a late stray pulse.
    model_lat = 0;
    req_valid = 4'b0100;
    run_op(120, 1'b0, 4'b0, 0, gnt, owner, res, err, lat, bad);
    check("wd_grant",   32'(gnt),   32'h4);
    check("wd_owner",   32'(owner), 32'h4);
    check("wd_result",  32'(res),   32'h7E00);
    check("wd_error",   32'(err),   32'd1);
    check("wd_latency", 32'(lat),   32'd64);
    check("wd_tocount", 32'(timeout_count), 32'd1);
    repeat (5) @(posedge clk_in);
    #1;
    inj_val = 16'h1234; inj_req++;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in); #1;
      if (rsp_valid != 4'b0 || busy) extra++;
    end
    check("late_pulse_ignored", 32'(extra), 32'd0);
    check("late_tocount", 32'(timeout_count), 32'd1);

    // Backpressure on lane 2 while lanes 0 and 3 wait.
    model_lat = 24; model_result = 16'h3555;
    req_valid = 4'b0100;
    run_op(80, 1'b0, 4'b1001, 10, gnt, owner, res, err, lat, bad);
    check("bp_grant",  32'(gnt),   32'h4);
    check("bp_owner",  32'(owner), 32'h4);
    check("bp_result", 32'(res),   32'h3555);
    check("bp_stable", 32'(bad),   32'd0);
    run_op(80, 1'b0, 4'b0, 0, gnt, owner, res, err, lat, bad);
    check("bp_next_grant3", 32'(gnt), 32'h8);
    run_op(80, 1'b0, 4'b0, 0, gnt, owner, res, err, lat, bad);
    check("bp_next_grant0", 32'(gnt), 32'h1);

    // Asynchronous reset in WAIT cycle 10.
    req_a[31:16] = 16'h4200; req_b[31:16] = 16'h4000;
    req_valid = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk_in); #1;
      if (div_valid_in) seen = 1'b1;
    end
    check("rst_issue_seen", 32'(seen), 32'd1);
    req_valid = '0;
    repeat (10) @(posedge clk_in);
    #1;
    check("rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    req_valid = 4'b1010;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    run_op(80, 1'b0, 4'b0, 0, gnt, owner, res, err, lat, bad);
    check("postrst_grant1", 32'(gnt), 32'h2);
    run_op(80, 1'b0, 4'b0, 0, gnt, owner, res, err, lat, bad);
    check("postrst_grant3", 32'(gnt), 32'h8);

    // Divider answers in the same cycle the watchdog would fire.
    model_lat = 63; model_result = 16'h3800;
    req_valid = 4'b0001;
    run_op(120, 1'b0, 4'b0, 0, gnt, owner, res, err, lat, bad);
    check("coin_owner",   32'(owner), 32'h1);
    check("coin_result",  32'(res),   32'h3800);
    check("coin_error",   32'(err),   32'd0);
    check("coin_latency", 32'(lat),   32'd64);
    check("coin_tocount", 32'(timeout_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/binary16_div_arbiter.md
Name: binary16_div_arbiter

Overview:
Shares one binary16_div instance between NUM_REQ requesters using round-robin arbitration with valid/ready handshakes.
Sequences each operation: grant, one-cycle issue pulse, wait for the divider's completion pulse, then return the result to the owning requester.
A watchdog returns qNaN with an error flag if the divider never answers.
Sits between the simulator's FP execution lanes and the single divider.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 63, WAIT cycles before watchdog fires (must exceed the divider's nominal 24-cycle latency)
TAG_W, $clog2(NUM_REQ), requester index width (derived, not overridden)

Ports:
clk_in  in  1  single clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid; held until ready seen
req_ready  out  NUM_REQ  one-hot grant/accept, registered
req_a  in  NUM_REQ*16  flattened dividends, slot i = bits [16i+15:16i]
req_b  in  NUM_REQ*16  flattened divisors
rsp_valid  out  NUM_REQ  one-hot response valid
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_result  out  16  binary16 quotient for the rsp_valid owner
rsp_error  out  1  1 = watchdog timeout, rsp_result = 16'h7E00
div_a  out  16  operand a to divider
div_b  out  16  operand b to divider
div_valid_in  out  1  one-cycle start pulse to divider
div_result  in  16  divider result
div_valid_out  in  1  divider completion pulse
busy  out  1  high in every state except IDLE
timeout_count  out  8  saturating count of watchdog events

Behaviour:
- Reset (rst_n low, async): state IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority.
- Outputs cleared on reset: req_ready, rsp_valid, rsp_result, rsp_error, div_a, div_b, div_valid_in, busy, timeout_count.
- All outputs are registered. One operation is in flight at a time.
- States and transitions:
  - IDLE: if any req_valid, pick g = first asserted index searching upward from last_grant+1 (mod NUM_REQ); register g -> GRANT. Otherwise stay.
  - GRANT (1 cycle): req_ready[g]=1; latch req_a/req_b slot g into div_a/div_b; tag = g -> ISSUE. Requesters must hold req_valid until ready; a dropped valid is still consumed.
  - ISSUE (1 cycle): div_valid_in=1 -> WAIT, timer = 0.
  - WAIT: timer increments each cycle.
    - On div_valid_out: rsp_result = div_result, rsp_error = 0 -> RESPOND.
    - Else if timer == TIMEOUT_CYCLES-1: rsp_result = 16'h7E00, rsp_error = 1, timeout_count += 1 (saturates at 255) -> RESPOND.
    - If div_valid_out arrives in the timeout cycle, the divider result wins.
  - RESPOND: rsp_valid[tag]=1; rsp_result and rsp_error held stable until rsp_ready[tag]. On accept: rsp_valid cleared, last_grant = tag -> IDLE.
- div_a/div_b stay stable from ISSUE until the next GRANT.
- div_valid_out outside WAIT (late pulse after a timeout) is ignored.
- Latency: request seen in IDLE cycle 0 -> ready in cycle 1 -> issue in cycle 2 -> response valid 1 cycle after div_valid_out. Minimum turnaround between grants is 1 IDLE cycle after accept.
- rsp_ready on non-owner lines is ignored. req_valid from other requesters during an operation waits; no starvation (round-robin).
- Reset mid-operation aborts immediately. Any later stray div_valid_out is ignored, because the block is not in WAIT.

Decomposition:
- binary16_pkg: BINARY16_QNAN = 16'h7E00, arbiter state enum (IDLE, GRANT, ISSUE, WAIT, RESPOND), DIV_NOMINAL_LATENCY = 24.
- Sub-module rr_arbiter: combinational round-robin pick of a NUM_REQ request vector given last_grant; outputs index and any_req.

Test Plan:
- Single op: req 0, a=16'h4000, b=16'h3C00; divider model returns 16'h4000 24 cycles after div_valid_in -> rsp_valid=4'b0001, rsp_result=16'h4000, rsp_error=0, response 25 cycles after ISSUE.
- Round robin: all four req_valid held high, rsp_ready tied high -> grant order 0,1,2,3,0,1; no requester granted twice before the others are served.
- Watchdog: model never pulses div_valid_out -> rsp_result=16'h7E00, rsp_error=1 after 63 WAIT cycles; timeout_count=1. A late pulse 5 cycles later is ignored and causes no extra rsp_valid.
- Backpressure: rsp_ready[2] low for 10 cycles during RESPOND -> rsp_valid[2] and rsp_result stable; req_ready stays 0 for the others; grant resumes after accept.
- Reset mid-WAIT: drop rst_n in cycle 10 of WAIT -> all outputs 0 asynchronously; after release with req 1 and 3 pending, first grant goes to 1.
- Coincident: div_valid_out in the timeout cycle (cycle 63) with result 16'h3800 -> rsp_result=16'h3800, rsp_error=0, timeout_count unchanged.
